// File: rtl/wb_intercon_pkg.sv
// Shared types and helpers for the Wishbone interconnect.
package wb_intercon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Ceiling log2 for parameter-time width calculations; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned x;
    int unsigned r;
    r = 0;
    x = (value == 0) ? 0 : value - 1;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_intercon_if.sv
// Bundle of master-side and slave-side Wishbone signals around the interconnect.
interface wb_intercon_if #(
  parameter int unsigned NSLAVES = 2,
  parameter int unsigned AW      = 30,
  parameter int unsigned DW      = 32
);
  localparam int unsigned SW = DW / 8;

  logic                  m_cyc_i;
  logic                  m_stb_i;
  logic                  m_we_i;
  logic [SW-1:0]         m_sel_i;
  logic [AW-1:0]         m_adr_i;
  logic [DW-1:0]         m_dat_i;
  logic [DW-1:0]         m_dat_o;
  logic                  m_ack_o;
  logic                  m_err_o;
  logic [NSLAVES-1:0]    s_cyc_o;
  logic [NSLAVES-1:0]    s_stb_o;
  logic                  s_we_o;
  logic [SW-1:0]         s_sel_o;
  logic [AW-1:0]         s_adr_o;
  logic [DW-1:0]         s_dat_o;
  logic [NSLAVES*DW-1:0] s_dat_i;
  logic [NSLAVES-1:0]    s_ack_i;

  // Interconnect view: a slave to the CPU, a master to the peripherals.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

  // Environment view: the CPU and the peripherals attached around the interconnect.
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
  );

endinterface

// File: rtl/wb_intercon_match.sv
// Address window matcher: one-hot hit vector, lowest index wins on overlap.
module wb_intercon_match #(
  parameter int unsigned          NSLAVES = 2,
  parameter int unsigned          AW      = 30,
  parameter logic [NSLAVES*AW-1:0] BASE   = '0,
  parameter logic [NSLAVES*AW-1:0] MASK   = '0
) (
  input  logic [AW-1:0]      adr,
  output logic [NSLAVES-1:0] hit_c,
  output logic               any_hit_c
);

  // Priority scan from slave 0 upward; first matching window claims the access.
  always_comb begin
    logic found;
    found = 1'b0;
    hit_c = '0;
    for (int unsigned i = 0; i < NSLAVES; i++) begin
      if (!found && ((adr & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW]))) begin
        hit_c[i] = 1'b1;
        found    = 1'b1;
      end
    end
    any_hit_c = found;
  end

endmodule

// File: rtl/wb_intercon.sv
// Single-master, N-slave Wishbone interconnect with decode error and bus timeout.
module wb_intercon
  import wb_intercon_pkg::*;
#(
  parameter int unsigned           NSLAVES = 2,
  parameter int unsigned           AW      = 30,
  parameter int unsigned           DW      = 32,
  // Slave 0 owns the low half, slave 1 the half selected by adr[29].
  parameter logic [NSLAVES*AW-1:0] BASE    = {30'h20000000, 30'h00000000},
  parameter logic [NSLAVES*AW-1:0] MASK    = {30'h20000000, 30'h20000000},
  parameter int unsigned           TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  wb_intercon_if.slave bus
);

  localparam int unsigned   SW       = DW / 8;
  localparam int unsigned   CW       = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [NSLAVES-1:0] sel_q, sel_d;
  logic [NSLAVES-1:0] strobe_q, strobe_d;
  logic               we_q, we_d;
  logic [SW-1:0]      bsel_q, bsel_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic [DW-1:0]      wdat_q, wdat_d;
  logic [DW-1:0]      rdat_q, rdat_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               err_pend_q, err_pend_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NSLAVES-1:0] hit_c;
  logic               any_hit_c;
  logic               slave_ack_c;
  logic [DW-1:0]      rdata_c;

  wb_intercon_match #(
    .NSLAVES (NSLAVES),
    .AW      (AW),
    .BASE    (BASE),
    .MASK    (MASK)
  ) u_match (
    .adr       (bus.m_adr_i),
    .hit_c     (hit_c),
    .any_hit_c (any_hit_c)
  );

  // Ack from the latched slave only; strays from other ports are dropped here.
  assign slave_ack_c = |(bus.s_ack_i & sel_q);

  // One-hot read-data select for the latched slave.
  always_comb begin
    rdata_c = '0;
    for (int unsigned i = 0; i < NSLAVES; i++) begin
      if (sel_q[i]) begin
        rdata_c = rdata_c | bus.s_dat_i[i*DW +: DW];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      strobe_q   <= '0;
      we_q       <= 1'b0;
      bsel_q     <= '0;
      adr_q      <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      strobe_q   <= strobe_d;
      we_q       <= we_d;
      bsel_q     <= bsel_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    strobe_d   = strobe_q;
    we_d       = we_q;
    bsel_d     = bsel_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    err_pend_d = err_pend_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.m_cyc_i && bus.m_stb_i) begin
          sel_d  = hit_c;
          we_d   = bus.m_we_i;
          bsel_d = bus.m_sel_i;
          adr_d  = bus.m_adr_i;
          wdat_d = bus.m_dat_i;
          cnt_d  = '0;
          if (any_hit_c) begin
            state_d  = BUSY;
            strobe_d = hit_c;
          end else begin
            state_d    = RESP;
            err_pend_d = 1'b1;
          end
        end
      end

      BUSY: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (!bus.m_cyc_i) begin
          state_d  = IDLE;
          strobe_d = '0;
        end else if (slave_ack_c) begin
          state_d  = RESP;
          strobe_d = '0;
          ack_d    = 1'b1;
          if (!we_q) begin
            rdat_d = rdata_c;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d  = RESP;
          strobe_d = '0;
          err_d    = 1'b1;
        end
      end

      RESP: begin
        // A decode miss spends one extra RESP cycle so its error arrives with
        // the same latency as a zero-wait slave ack.
        if (err_pend_q) begin
          err_pend_d = 1'b0;
          err_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        strobe_d = '0;
      end
    endcase
  end

  assign bus.m_dat_o = rdat_q;
  assign bus.m_ack_o = ack_q;
  assign bus.m_err_o = err_q;
  assign bus.s_cyc_o = strobe_q;
  assign bus.s_stb_o = strobe_q;
  assign bus.s_we_o  = we_q;
  assign bus.s_sel_o = bsel_q;
  assign bus.s_adr_o = adr_q;
  assign bus.s_dat_o = wdat_q;

endmodule

// File: tb/tb_wb_intercon.sv
// Directed bench for wb_intercon: three configurations sharing one clock and reset.
`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_wb_intercon;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  // A: default two-slave map. B: three slaves with a hole, short timeout.
  // C: fully overlapping windows, timeout of 4.
  wb_intercon_if #(.NSLAVES(2), .AW(30), .DW(32)) ia ();
  wb_intercon_if #(.NSLAVES(3), .AW(30), .DW(32)) ib ();
  wb_intercon_if #(.NSLAVES(2), .AW(30), .DW(32)) ic ();

  wb_intercon #(
    .NSLAVES (2), .AW (30), .DW (32),
    .BASE    ({30'h20000000, 30'h00000000}),
    .MASK    ({30'h20000000, 30'h20000000}),
    .TIMEOUT (255)
  ) u_a (.clk(clk), .reset(reset), .bus(ia));

  wb_intercon #(
    .NSLAVES (3), .AW (30), .DW (32),
    .BASE    ({30'h10000000, 30'h20000000, 30'h00000000}),
    .MASK    ({30'h30000000, 30'h30000000, 30'h30000000}),
    .TIMEOUT (8)
  ) u_b (.clk(clk), .reset(reset), .bus(ib));

  wb_intercon #(
    .NSLAVES (2), .AW (30), .DW (32),
    .BASE    ({30'h00000000, 30'h00000000}),
    .MASK    ({30'h20000000, 30'h20000000}),
    .TIMEOUT (4)
  ) u_c (.clk(clk), .reset(reset), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    ia.m_cyc_i = 0; ia.m_stb_i = 0; ia.m_we_i = 0; ia.m_sel_i = '0; ia.m_adr_i = '0;
    ia.m_dat_i = '0; ia.s_dat_i = '0; ia.s_ack_i = '0;
    ib.m_cyc_i = 0; ib.m_stb_i = 0; ib.m_we_i = 0; ib.m_sel_i = '0; ib.m_adr_i = '0;
    ib.m_dat_i = '0; ib.s_dat_i = '0; ib.s_ack_i = '0;
    ic.m_cyc_i = 0; ic.m_stb_i = 0; ic.m_we_i = 0; ic.m_sel_i = '0; ic.m_adr_i = '0;
    ic.m_dat_i = '0; ic.s_dat_i = '0; ic.s_ack_i = '0;

    tick();
    tick();
    `CHK("rst_ack",  ia.m_ack_o, 1'b0);
    `CHK("rst_err",  ia.m_err_o, 1'b0);
    `CHK("rst_stb",  ia.s_stb_o, 2'b00);
    `CHK("rst_cyc",  ia.s_cyc_o, 2'b00);
    `CHK("rst_we",   ia.s_we_o,  1'b0);
    `CHK("rst_dat",  ia.m_dat_o, 32'h0);
    `CHK("rst_adr",  ia.s_adr_o, 30'h0);
    `CHK("rst_b_stb", ib.s_stb_o, 3'b000);
    reset = 1'b0;
    tick();

    // Read from slave 0, combinational ack in cycle 1.
    ia.m_cyc_i = 1; ia.m_stb_i = 1; ia.m_we_i = 0; ia.m_sel_i = 4'hF; ia.m_adr_i = 30'h10;
    tick();
    `CHK("rd_c1_stb", ia.s_stb_o, 2'b01);
    `CHK("rd_c1_cyc", ia.s_cyc_o, 2'b01);
    `CHK("rd_c1_ack", ia.m_ack_o, 1'b0);
    `CHK("rd_c1_adr", ia.s_adr_o, 30'h10);
    ia.s_ack_i = 2'b01; ia.s_dat_i = {32'h0, 32'hDEADBEEF};
    tick();
    ia.s_ack_i = 2'b00;
    `CHK("rd_c2_ack", ia.m_ack_o, 1'b1);
    `CHK("rd_c2_err", ia.m_err_o, 1'b0);
    `CHK("rd_c2_dat", ia.m_dat_o, 32'hDEADBEEF);
    `CHK("rd_c2_stb", ia.s_stb_o, 2'b00);
    ia.m_cyc_i = 0; ia.m_stb_i = 0;
    tick();
    `CHK("rd_c3_ack", ia.m_ack_o, 1'b0);

    // Write to slave 1 with three wait states.
    ia.m_cyc_i = 1; ia.m_stb_i = 1; ia.m_we_i = 1; ia.m_sel_i = 4'b0001;
    ia.m_adr_i = 30'h20000004; ia.m_dat_i = 32'h41;
    tick();
    `CHK("wr_c1_stb", ia.s_stb_o, 2'b10);
    `CHK("wr_c1_we",  ia.s_we_o,  1'b1);
    `CHK("wr_c1_dat", ia.s_dat_o, 32'h41);
    `CHK("wr_c1_sel", ia.s_sel_o, 4'b0001);
    `CHK("wr_c1_adr", ia.s_adr_o, 30'h20000004);
    tick();
    tick();
    `CHK("wr_c3_stb", ia.s_stb_o, 2'b10);
    `CHK("wr_c3_ack", ia.m_ack_o, 1'b0);
    tick();
    `CHK("wr_c4_ack", ia.m_ack_o, 1'b0);
    ia.s_ack_i = 2'b10;
    tick();
    ia.s_ack_i = 2'b00;
    `CHK("wr_c5_ack", ia.m_ack_o, 1'b1);
    `CHK("wr_c5_err", ia.m_err_o, 1'b0);
    `CHK("wr_c5_dat", ia.m_dat_o, 32'hDEADBEEF);
    ia.m_cyc_i = 0; ia.m_stb_i = 0; ia.m_we_i = 0;
    tick();
    `CHK("wr_c6_ack", ia.m_ack_o, 1'b0);

    // Abort: master drops cyc while the slave is strobed.
    ia.m_cyc_i = 1; ia.m_stb_i = 1; ia.m_adr_i = 30'h10;
    tick();
    `CHK("ab_c1_stb", ia.s_stb_o, 2'b01);
    ia.m_cyc_i = 0; ia.m_stb_i = 0;
    tick();
    `CHK("ab_c2_stb", ia.s_stb_o, 2'b00);
    `CHK("ab_c2_ack", ia.m_ack_o, 1'b0);
    `CHK("ab_c2_err", ia.m_err_o, 1'b0);
    tick();
    `CHK("ab_c3_ack", ia.m_ack_o, 1'b0);
    `CHK("ab_c3_err", ia.m_err_o, 1'b0);

    // Unmapped address on B: error two cycles after the strobe is sampled.
    ib.m_cyc_i = 1; ib.m_stb_i = 1; ib.m_adr_i = 30'h30000000;
    tick();
    `CHK("um_c1_stb", ib.s_stb_o, 3'b000);
    `CHK("um_c1_err", ib.m_err_o, 1'b0);
    tick();
    `CHK("um_c2_err", ib.m_err_o, 1'b1);
    `CHK("um_c2_ack", ib.m_ack_o, 1'b0);
    `CHK("um_c2_stb", ib.s_stb_o, 3'b000);
    ib.m_cyc_i = 0; ib.m_stb_i = 0;
    tick();
    `CHK("um_c3_err", ib.m_err_o, 1'b0);

    // Read from slave 2 on B.
    ib.m_cyc_i = 1; ib.m_stb_i = 1; ib.m_adr_i = 30'h10000000;
    tick();
    `CHK("s2_c1_stb", ib.s_stb_o, 3'b100);
    ib.s_ack_i = 3'b100; ib.s_dat_i = {32'hCAFEF00D, 64'h0};
    tick();
    ib.s_ack_i = 3'b000;
    `CHK("s2_c2_ack", ib.m_ack_o, 1'b1);
    `CHK("s2_c2_dat", ib.m_dat_o, 32'hCAFEF00D);
    ib.m_cyc_i = 0; ib.m_stb_i = 0;
    tick();

    // Timeout on B: slave 0 never acks, strobe held for 8 cycles.
    ib.m_cyc_i = 1; ib.m_stb_i = 1; ib.m_adr_i = 30'h4;
    for (int k = 1; k <= 8; k++) begin
      tick();
      `CHK($sformatf("to_c%0d_stb", k), ib.s_stb_o, 3'b001);
      `CHK($sformatf("to_c%0d_err", k), ib.m_err_o, 1'b0);
      n_vec++;
      if (ib.s_stb_o !== 3'b001) begin
        n_err++;
        $error("FAIL to_loop_stb cycle %0d: observed %0b", k, ib.s_stb_o);
      end
      n_vec++;
      if (ib.m_err_o !== 1'b0) begin
        n_err++;
        $error("FAIL to_loop_err cycle %0d: observed %0b", k, ib.m_err_o);
      end
    end
    tick();
    `CHK("to_c9_err", ib.m_err_o, 1'b1);
    `CHK("to_c9_ack", ib.m_ack_o, 1'b0);
    `CHK("to_c9_stb", ib.s_stb_o, 3'b000);
    ib.m_cyc_i = 0; ib.m_stb_i = 0;
    tick();
    `CHK("to_c10_err", ib.m_err_o, 1'b0);
    ib.s_ack_i = 3'b001; ib.s_dat_i = {64'h0, 32'h77777777};
    tick();
    ib.s_ack_i = 3'b000;
    `CHK("to_late_ack", ib.m_ack_o, 1'b0);
    `CHK("to_late_err", ib.m_err_o, 1'b0);
    `CHK("to_late_dat", ib.m_dat_o, 32'hCAFEF00D);
    `CHK("to_late_stb", ib.s_stb_o, 3'b000);

    // Overlap on C: slave 0 wins; stray ack from slave 1 is ignored.
    ic.m_cyc_i = 1; ic.m_stb_i = 1; ic.m_adr_i = 30'h100;
    tick();
    `CHK("ov_c1_stb", ic.s_stb_o, 2'b01);
    ic.s_ack_i = 2'b10; ic.s_dat_i = {32'h99999999, 32'h0};
    tick();
    `CHK("ov_c2_ack", ic.m_ack_o, 1'b0);
    `CHK("ov_c2_stb", ic.s_stb_o, 2'b01);
    ic.s_ack_i = 2'b01; ic.s_dat_i = {32'h99999999, 32'h0BADF00D};
    tick();
    ic.s_ack_i = 2'b00;
    `CHK("ov_c3_ack", ic.m_ack_o, 1'b1);
    `CHK("ov_c3_dat", ic.m_dat_o, 32'h0BADF00D);
    ic.m_cyc_i = 0; ic.m_stb_i = 0;
    tick();

    // Ack arriving in the last cycle before timeout on C: ack wins.
    ic.m_cyc_i = 1; ic.m_stb_i = 1; ic.m_adr_i = 30'h200;
    tick();
    tick();
    tick();
    `CHK("at_c3_stb", ic.s_stb_o, 2'b01);
    tick();
    `CHK("at_c4_stb", ic.s_stb_o, 2'b01);
    `CHK("at_c4_err", ic.m_err_o, 1'b0);
    ic.s_ack_i = 2'b01; ic.s_dat_i = {32'h0, 32'h13579BDF};
    tick();
    ic.s_ack_i = 2'b00;
    `CHK("at_c5_ack", ic.m_ack_o, 1'b1);
    `CHK("at_c5_err", ic.m_err_o, 1'b0);
    `CHK("at_c5_dat", ic.m_dat_o, 32'h13579BDF);
    ic.m_cyc_i = 0; ic.m_stb_i = 0;
    tick();
    `CHK("at_c6_err", ic.m_err_o, 1'b0);

    // Reset during BUSY on A, then a normal read.
    ia.m_cyc_i = 1; ia.m_stb_i = 1; ia.m_we_i = 1; ia.m_sel_i = 4'hF;
    ia.m_adr_i = 30'h20000008; ia.m_dat_i = 32'h55;
    tick();
    `CHK("rs_c1_stb", ia.s_stb_o, 2'b10);
    reset = 1'b1;
    ia.m_cyc_i = 0; ia.m_stb_i = 0; ia.m_we_i = 0;
    tick();
    `CHK("rs_c2_stb", ia.s_stb_o, 2'b00);
    `CHK("rs_c2_cyc", ia.s_cyc_o, 2'b00);
    `CHK("rs_c2_we",  ia.s_we_o,  1'b0);
    `CHK("rs_c2_adr", ia.s_adr_o, 30'h0);
    `CHK("rs_c2_wd",  ia.s_dat_o, 32'h0);
    `CHK("rs_c2_sel", ia.s_sel_o, 4'h0);
    `CHK("rs_c2_dat", ia.m_dat_o, 32'h0);
    `CHK("rs_c2_ack", ia.m_ack_o, 1'b0);
    reset = 1'b0;
    ia.m_cyc_i = 1; ia.m_stb_i = 1; ia.m_adr_i = 30'h20000000;
    tick();
    `CHK("rs_rd_stb", ia.s_stb_o, 2'b10);
    ia.s_ack_i = 2'b10; ia.s_dat_i = {32'h12345678, 32'h0};
    tick();
    ia.s_ack_i = 2'b00;
    `CHK("rs_rd_ack", ia.m_ack_o, 1'b1);
    `CHK("rs_rd_dat", ia.m_dat_o, 32'h12345678);
    n_vec++;
    if (ia.m_dat_o !== 32'h12345678) begin
      n_err++;
      $error("FAIL rs_rd_dat_inline: observed %0h", ia.m_dat_o);
    end
    n_vec++;
    if (ia.m_err_o !== 1'b0) begin
      n_err++;
      $error("FAIL rs_rd_err_inline: observed %0b", ia.m_err_o);
    end
    ia.m_cyc_i = 0; ia.m_stb_i = 0;
    tick();
    `CHK("rs_rd_end", ia.m_ack_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`undef CHK
